// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Holds the PC, issues one word read per
// fetch command over a req/ack handshake, latches the returned instruction and
// exposes its decoded fields.
// Optional feature macro: FETCH_TIMEOUT_EN (ack watchdog with sticky fetchErr).
module fetch_unit #(
  parameter int              ADDR_W      = 32,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INST    = 32'h6800_0000,
  parameter int              TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rstN,
  input  logic              ldPC,
  input  logic              clrPC,
  input  logic              isBranchTaken,
  input  logic [ADDR_W-1:0] brnchTarget,
  output logic              imemReq,
  output logic [ADDR_W-1:0] imemAddr,
  input  logic [31:0]       imemRdata,
  input  logic              imemAck,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] npc,
  output logic [31:0]       inst,
  output logic              instValid,
  output logic              busy,
  output logic [4:0]        opcode,
  output logic              iOrReg,
  output logic [1:0]        modifier,
  output logic              fetchErr
);

  typedef enum logic {S_IDLE, S_REQ} state_e;

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] WORD_STEP  = ADDR_W'(4);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] npc_q, npc_d;
  logic [31:0]       inst_q, inst_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] fetch_addr;

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  // Fetch address: branch target or sequential PC, forced word-aligned.
  assign fetch_addr = (isBranchTaken ? brnchTarget : npc_q) & ALIGN_MASK;

  // Next-state logic; priority is flush, then ack (or expiry), then ldPC.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path can infer a latch.
    state_d = state_q;
    pc_d    = pc_q;
    npc_d   = npc_q;
    inst_d  = inst_q;
    valid_d = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    if (clrPC) begin
      // Abandon any outstanding request; a late ack lands in IDLE and is ignored.
      state_d = S_IDLE;
      pc_d    = RESET_PC;
      npc_d   = RESET_PC;
      inst_d  = NOP_INST;
`ifdef FETCH_TIMEOUT_EN
      cnt_d   = '0;
      err_d   = 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (ldPC) begin
            pc_d    = fetch_addr;
            state_d = S_REQ;
`ifdef FETCH_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
        S_REQ: begin
          if (imemAck) begin
            inst_d  = imemRdata;
            npc_d   = pc_q + WORD_STEP;
            valid_d = 1'b1;
            state_d = S_IDLE;
`ifdef FETCH_TIMEOUT_EN
          end else if (cnt_q == CNT_LAST) begin
            // Watchdog expiry: complete the fetch with a NOP and flag the error.
            inst_d  = NOP_INST;
            npc_d   = pc_q + WORD_STEP;
            valid_d = 1'b1;
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            cnt_d   = cnt_q + 1'b1;
`endif
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rstN) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (!rstN) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      npc_q   <= RESET_PC;
      inst_q  <= NOP_INST;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      npc_q   <= npc_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  // Watchdog counter and sticky error flag.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign fetchErr = err_q;
`else
  assign fetchErr = 1'b0;
`endif

  // The request address is the PC of the instruction being fetched.
  assign imemReq   = (state_q == S_REQ);
  assign busy      = (state_q == S_REQ);
  assign imemAddr  = pc_q;
  assign pc        = pc_q;
  assign npc       = npc_q;
  assign inst      = inst_q;
  assign instValid = valid_q;
  assign opcode    = inst_q[31:27];
  assign iOrReg    = inst_q[26];
  assign modifier  = inst_q[17:16];

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized scoreboard bench for fetch_unit. The driver keeps a
// transaction-level model of the next sequential address and pushes expected
// requests and completions; a monitor compares them as the DUT presents them.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0;
  localparam logic [31:0] NOP    = 32'h6800_0000;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] inst;
  } exp_t;

  logic        clk, rstN;
  logic        ldPC, clrPC, isBranchTaken;
  logic [31:0] brnchTarget;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic [31:0] imemRdata;
  logic        imemAck;
  logic [31:0] pc, npc, inst;
  logic        instValid, busy, iOrReg, fetchErr;
  logic [4:0]  opcode;
  logic [1:0]  modifier;

  exp_t        exp_q[$];
  logic [31:0] addr_q[$];
  logic [31:0] m_npc;
  logic [31:0] cur_addr;
  logic        prev_req;
  int          total = 0;
  int          bad   = 0;

  fetch_unit dut (
    .clk(clk), .rstN(rstN), .ldPC(ldPC), .clrPC(clrPC),
    .isBranchTaken(isBranchTaken), .brnchTarget(brnchTarget),
    .imemReq(imemReq), .imemAddr(imemAddr), .imemRdata(imemRdata),
    .imemAck(imemAck), .pc(pc), .npc(npc), .inst(inst),
    .instValid(instValid), .busy(busy), .opcode(opcode),
    .iOrReg(iOrReg), .modifier(modifier), .fetchErr(fetchErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compare request addresses and completions against the scoreboard.
  initial begin
    exp_t        e;
    logic [31:0] a;
    prev_req = 1'b0;
    cur_addr = '0;
    forever begin
      @(negedge clk);
      if (!rstN) begin
        prev_req = 1'b0;
      end else begin
        if (imemReq && !prev_req) begin
          if (addr_q.size() == 0) begin
            check("spurious_req", {31'b0, imemReq}, 32'd0);
          end else begin
            a = addr_q.pop_front();
            cur_addr = a;
            check("req_addr", imemAddr, a);
            check("busy_with_req", {31'b0, busy}, 32'd1);
          end
        end else if (imemReq) begin
          check("addr_hold", imemAddr, cur_addr);
        end
        if (instValid) begin
          if (exp_q.size() == 0) begin
            check("spurious_valid", {31'b0, instValid}, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("done_pc", pc, e.pc);
            check("done_npc", npc, e.npc);
            check("done_inst", inst, e.inst);
            check("done_opcode", {27'b0, opcode}, {27'b0, e.inst[31:27]});
            check("done_iorreg", {31'b0, iOrReg}, {31'b0, e.inst[26]});
            check("done_modifier", {30'b0, modifier}, {30'b0, e.inst[17:16]});
            check("done_req_low", {31'b0, imemReq}, 32'd0);
          end
        end
        prev_req = imemReq;
      end
    end
  end

  // One complete fetch: ldPC, dly ack-less cycles, then ack with data.
  task automatic do_fetch(input bit br, input logic [31:0] tgt, input int dly,
                          input logic [31:0] data, input bit noise);
    logic [31:0] a;
    @(posedge clk); #1;
    ldPC = 1'b1; isBranchTaken = br; brnchTarget = tgt;
    a = (br ? tgt : m_npc) & 32'hFFFF_FFFC;
    addr_q.push_back(a);
    @(posedge clk); #1;
    ldPC = 1'b0; isBranchTaken = 1'($urandom); brnchTarget = $urandom;
    for (int i = 0; i < dly; i++) begin
      ldPC = noise & 1'($urandom);
      @(posedge clk); #1;
    end
    ldPC = noise & 1'($urandom);
    imemAck = 1'b1; imemRdata = data;
    exp_q.push_back('{pc: a, npc: a + 32'd4, inst: data});
    m_npc = a + 32'd4;
    @(posedge clk); #1;
    imemAck = 1'b0; ldPC = 1'b0;
  endtask

  // Flush while idle.
  task automatic do_clear();
    @(posedge clk); #1;
    clrPC = 1'b1;
    m_npc = RST_PC;
    @(posedge clk); #1;
    clrPC = 1'b0;
  endtask

  // Start a fetch, flush it mid-request, then deliver a late ack.
  task automatic do_flush_mid(input int dly);
    @(posedge clk); #1;
    ldPC = 1'b1; isBranchTaken = 1'b0;
    addr_q.push_back(m_npc);
    @(posedge clk); #1;
    ldPC = 1'b0;
    repeat (dly) begin @(posedge clk); #1; end
    clrPC = 1'b1;
    m_npc = RST_PC;
    @(posedge clk); #1;
    clrPC = 1'b0;
    check("flush_req", {31'b0, imemReq}, 32'd0);
    check("flush_inst", inst, NOP);
    check("flush_npc", npc, RST_PC);
    imemAck = 1'b1; imemRdata = $urandom;
    @(posedge clk); #1;
    imemAck = 1'b0;
    check("late_ack_inst", inst, NOP);
    check("late_ack_valid", {31'b0, instValid}, 32'd0);
  endtask

  // clrPC and ldPC together: flush only, no request.
  task automatic do_clr_and_ld();
    @(posedge clk); #1;
    clrPC = 1'b1; ldPC = 1'b1; isBranchTaken = 1'($urandom); brnchTarget = $urandom;
    m_npc = RST_PC;
    @(posedge clk); #1;
    clrPC = 1'b0; ldPC = 1'b0;
    check("clr_ld_req", {31'b0, imemReq}, 32'd0);
    check("clr_ld_pc", pc, RST_PC);
  endtask

  initial begin
    int r;
    rstN = 1'b0; ldPC = 1'b0; clrPC = 1'b0; isBranchTaken = 1'b0;
    brnchTarget = '0; imemRdata = '0; imemAck = 1'b0;
    m_npc = RST_PC;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", pc, RST_PC);
    check("rst_npc", npc, RST_PC);
    check("rst_inst", inst, NOP);
    check("rst_req", {31'b0, imemReq}, 32'd0);
    check("rst_valid", {31'b0, instValid}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_err", {31'b0, fetchErr}, 32'd0);
    check("rst_opcode", {27'b0, opcode}, 32'd13);
    rstN = 1'b1;

    // First fetch from reset address with known data.
    do_fetch(1'b0, 32'h0, 0, 32'h0812_0005, 1'b0);
    check("first_opcode", {27'b0, opcode}, 32'd1);
    check("first_iorreg", {31'b0, iOrReg}, 32'd0);
    check("first_modifier", {30'b0, modifier}, 32'd2);
    check("first_npc", npc, 32'd4);

    // Sequential fetches 0, 4, 8 with ldPC noise during REQ.
    do_clear();
    do_fetch(1'b0, 32'h0, 1, $urandom, 1'b1);
    do_fetch(1'b0, 32'h0, 3, $urandom, 1'b1);
    do_fetch(1'b0, 32'h0, 0, $urandom, 1'b1);
    check("seq_npc", npc, 32'd12);

    // Unaligned branch target is word-aligned.
    do_fetch(1'b1, 32'h0000_0103, 2, $urandom, 1'b0);
    check("branch_pc", pc, 32'h100);
    check("branch_npc", npc, 32'h104);

    // Flush cases.
    do_flush_mid(2);
    do_clr_and_ld();
    do_fetch(1'b0, 32'h0, 0, $urandom, 1'b0);
    check("after_flush_pc", pc, RST_PC);

    // Asynchronous reset mid-request.
    @(posedge clk); #1;
    ldPC = 1'b1; isBranchTaken = 1'b1; brnchTarget = 32'h40;
    addr_q.push_back(32'h40);
    @(posedge clk); #1;
    ldPC = 1'b0;
    @(posedge clk); #2;
    rstN = 1'b0;
    m_npc = RST_PC;
    #1;
    check("arst_req", {31'b0, imemReq}, 32'd0);
    check("arst_pc", pc, RST_PC);
    check("arst_inst", inst, NOP);
    check("arst_busy", {31'b0, busy}, 32'd0);
    #3 rstN = 1'b1;
    do_fetch(1'b0, 32'h0, 1, $urandom, 1'b0);
    check("arst_first_pc", pc, RST_PC);

    // Address wrap.
    do_fetch(1'b1, 32'hFFFF_FFFF, 1, $urandom, 1'b0);
    check("wrap_pc", pc, 32'hFFFF_FFFC);
    check("wrap_npc", npc, 32'h0);

`ifdef FETCH_TIMEOUT_EN
    // No ack: watchdog completes with a NOP and sets the sticky error.
    @(posedge clk); #1;
    ldPC = 1'b1; isBranchTaken = 1'b1; brnchTarget = 32'h200;
    addr_q.push_back(32'h200);
    exp_q.push_back('{pc: 32'h200, npc: 32'h204, inst: NOP});
    m_npc = 32'h204;
    @(posedge clk); #1;
    ldPC = 1'b0;
    repeat (18) begin @(posedge clk); #1; end
    check("tmo_err", {31'b0, fetchErr}, 32'd1);
    check("tmo_req", {31'b0, imemReq}, 32'd0);
    do_clear();
    check("tmo_err_clr", {31'b0, fetchErr}, 32'd0);
    // Ack on the expiry edge wins.
    do_fetch(1'b0, 32'h0, 15, 32'h1234_5678, 1'b0);
    check("tmo_ack_err", {31'b0, fetchErr}, 32'd0);
    check("tmo_ack_inst", inst, 32'h1234_5678);
`endif

    // Randomized mix with spurious idle acks.
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 2);
      for (int k = 0; k < r; k++) begin
        @(posedge clk); #1;
        imemAck = 1'($urandom); imemRdata = $urandom;
      end
      @(posedge clk); #1;
      imemAck = 1'b0;
      r = $urandom_range(0, 9);
      if (r == 0)      do_flush_mid($urandom_range(0, 3));
      else if (r == 1) do_clr_and_ld();
      else if (r == 2) do_clear();
      else if (r < 6)  do_fetch(1'b1, $urandom, $urandom_range(0, 5), $urandom, 1'b1);
      else             do_fetch(1'b0, 32'h0, $urandom_range(0, 5), $urandom, 1'b1);
    end

    repeat (3) @(posedge clk);
    #1;
    check("exp_drained", exp_q.size(), 32'd0);
    check("addr_drained", addr_q.size(), 32'd0);
    check("final_npc", npc, m_npc);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
